// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU integer-conversion stage: FSM states,
// IEEE-754 single constants, saturation limits and flag bit positions.
package fpu_pkg;

  typedef enum logic [2:0] {
    ST_GET_A   = 3'd0,
    ST_UNPACK  = 3'd1,
    ST_SPECIAL = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_ROUND   = 3'd4,
    ST_PACK    = 3'd5,
    ST_PUT_Z   = 3'd6
  } fp2int_state_t;

  localparam int unsigned FP_EXP_BIAS = 127;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  localparam int unsigned FLAG_INVALID = 1;
  localparam int unsigned FLAG_INEXACT = 0;

endpackage

// File: rtl/fp_to_int.sv
// Multi-cycle float32 -> int32 converter with strobe/ack handshakes on both sides.
// Define FP2INT_ROUND_NEAREST_EN for round-to-nearest-even; otherwise truncates toward zero.
//
// state      | meaning
// get_a      | ack high, waiting for an operand
// unpack     | split sign/exponent, build left-aligned mantissa
// special    | NaN / saturation short-cut, else load shift count
// shift      | shift mantissa right one bit per cycle, collect guard/sticky
// round      | compute inexact, optionally round to nearest even
// pack       | apply sign, update result and flag registers
// put_z      | present result until the consumer acks
module fp_to_int
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [1:0]  output_flags,
  output logic        busy
);

  fp2int_state_t     state_q, state_d;
  logic [31:0]       a_q, a_d;
  logic              s_q, s_d;
  logic signed [9:0] e_q, e_d;
  logic [31:0]       r_q, r_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [5:0]        n_q, n_d;
  logic              inv_q, inv_d;
  logic              inex_q, inex_d;
  logic [31:0]       z_q, z_d;
  logic [1:0]        flags_q, flags_d;
  logic              in_ack_q, in_ack_d;
  logic              out_stb_q, out_stb_d;
  logic signed [9:0] n_full;

  assign n_full = 10'sd31 - e_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    s_d       = s_q;
    e_d       = e_q;
    r_d       = r_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    n_d       = n_q;
    inv_d     = inv_q;
    inex_d    = inex_q;
    z_d       = z_q;
    flags_d   = flags_q;
    in_ack_d  = in_ack_q;
    out_stb_d = out_stb_q;

    case (state_q)
      ST_GET_A: begin
        in_ack_d = 1'b1;
        if (input_a_stb && in_ack_q) begin
          a_d      = input_a;
          in_ack_d = 1'b0;
          state_d  = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        s_d      = a_q[31];
        e_d      = $signed({2'b00, a_q[30:23]}) - 10'sd127;
        r_d      = (a_q[30:23] == 8'h00) ? 32'h0 : {1'b1, a_q[22:0], 8'h00};
        guard_d  = 1'b0;
        sticky_d = 1'b0;
        inv_d    = 1'b0;
        inex_d   = 1'b0;
        state_d  = ST_SPECIAL;
      end
      ST_SPECIAL: begin
        // Special results are staged as a positive r so pack needs no extra mux.
        if (a_q[30:23] == 8'hFF && a_q[22:0] != 23'h0) begin
          s_d     = 1'b0;
          r_d     = INT32_MIN;
          inv_d   = 1'b1;
          state_d = ST_PACK;
        end else if (e_q >= 10'sd31) begin
          s_d     = 1'b0;
          if (a_q == 32'hCF00_0000) begin
            r_d   = INT32_MIN;
            inv_d = 1'b0;
          end else begin
            r_d   = s_q ? INT32_MIN : INT32_MAX;
            inv_d = 1'b1;
          end
          state_d = ST_PACK;
        end else begin
          n_d     = (n_full > 10'sd33) ? 6'd33 : n_full[5:0];
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        r_d      = r_q >> 1;
        guard_d  = r_q[0];
        sticky_d = sticky_q | guard_q;
        n_d      = n_q - 6'd1;
        if (n_q == 6'd1) state_d = ST_ROUND;
      end
      ST_ROUND: begin
        inex_d = guard_q | sticky_q;
`ifdef FP2INT_ROUND_NEAREST_EN
        if (guard_q && (sticky_q || r_q[0])) r_d = r_q + 32'd1;
`endif
        state_d = ST_PACK;
      end
      ST_PACK: begin
        z_d                   = s_q ? (~r_q + 32'd1) : r_q;
        flags_d[FLAG_INVALID] = inv_q;
        flags_d[FLAG_INEXACT] = inex_q;
        state_d               = ST_PUT_Z;
      end
      ST_PUT_Z: begin
        out_stb_d = 1'b1;
        if (out_stb_q && output_z_ack) begin
          out_stb_d = 1'b0;
          state_d   = ST_GET_A;
        end
      end
      default: state_d = ST_GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_GET_A;
      a_q       <= 32'h0;
      s_q       <= 1'b0;
      e_q       <= 10'sd0;
      r_q       <= 32'h0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      n_q       <= 6'd0;
      inv_q     <= 1'b0;
      inex_q    <= 1'b0;
      z_q       <= 32'h0;
      flags_q   <= 2'b00;
      in_ack_q  <= 1'b0;
      out_stb_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      s_q       <= s_d;
      e_q       <= e_d;
      r_q       <= r_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      n_q       <= n_d;
      inv_q     <= inv_d;
      inex_q    <= inex_d;
      z_q       <= z_d;
      flags_q   <= flags_d;
      in_ack_q  <= in_ack_d;
      out_stb_q <= out_stb_d;
    end
  end

  assign input_a_ack  = in_ack_q;
  assign output_z     = z_q;
  assign output_z_stb = out_stb_q;
  assign output_flags = flags_q;
  assign busy         = (state_q != ST_GET_A);

endmodule
